// File: rtl/life_pkg.sv
// Shared constants and types for the Game-of-Life generation engine.
package life_pkg;

  localparam int COLS_LOG2_DEF = 3;
  localparam int ROWS_LOG2_DEF = 3;
  localparam int COLS          = 2 ** COLS_LOG2_DEF;
  localparam int ROWS          = 2 ** ROWS_LOG2_DEF;
  localparam int SIZE          = COLS * ROWS;
  localparam int IDX_W         = COLS_LOG2_DEF + ROWS_LOG2_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    SWAP    = 2'd2
  } state_t;

  // Conway B3/S23, plus HighLife birth rule B36
  localparam logic [8:0] B3_MASK  = 9'b000001000;
  localparam logic [8:0] S23_MASK = 9'b000001100;
  localparam logic [8:0] B36_MASK = 9'b001001000;

endpackage

// File: rtl/life_rule.sv
// Combinational cell rule: counts the valid live neighbours of a 3x3 window
// and applies the birth/survival masks to the centre cell.
module life_rule import life_pkg::*; #(
  parameter logic [8:0] BIRTH_MASK   = B3_MASK,
  parameter logic [8:0] SURVIVE_MASK = S23_MASK
) (
  input  logic [8:0] window,
  input  logic [8:0] valid,
  output logic [3:0] count,
  output logic       next_cell
);

  // window is row-major, bit 4 is the centre cell and is never counted
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) begin
        count = count + 4'(window[i] & valid[i]);
      end
    end
    next_cell = window[4] ? SURVIVE_MASK[count] : BIRTH_MASK[count];
  end

endmodule

// File: rtl/life_engine.sv
// Double-buffered Game-of-Life engine: computes one cell per clock from the
// front buffer into the back buffer, then swaps the buffers in one cycle.
module life_engine import life_pkg::*; #(
  parameter int         COLS_LOG2    = 3,
  parameter int         ROWS_LOG2    = 3,
  parameter bit         TORUS        = 1'b0,
  parameter int         GEN_FRAMES   = 60,
  parameter logic [8:0] BIRTH_MASK   = B3_MASK,
  parameter logic [8:0] SURVIVE_MASK = S23_MASK,
  parameter logic [2**(COLS_LOG2+ROWS_LOG2)-1:0] INIT_PATTERN = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_tick,
  input  logic                           run,
  input  logic                           step,
  input  logic                           clear,
  input  logic                           load_en,
  input  logic [COLS_LOG2+ROWS_LOG2-1:0] load_addr,
  input  logic                           load_data,
  input  logic [COLS_LOG2-1:0]           rd_col,
  input  logic [ROWS_LOG2-1:0]           rd_row,
  output logic                           rd_cell,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    gen_count,
  output logic [COLS_LOG2+ROWS_LOG2:0]   population
);

  localparam int AW     = COLS_LOG2 + ROWS_LOG2;
  localparam int N_SIZE = 2 ** AW;
  localparam int FW     = (GEN_FRAMES > 1) ? $clog2(GEN_FRAMES) : 1;

  function automatic logic [AW:0] popcount(input logic [N_SIZE-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < N_SIZE; i++) begin
      c = c + (AW+1)'(v[i]);
    end
    return c;
  endfunction

  localparam logic [AW:0] INIT_POP = popcount(INIT_PATTERN);

  state_t            state_reg, state_next;
  logic [N_SIZE-1:0] front_reg, back_reg;
  logic [AW-1:0]     idx_reg;
  logic [AW:0]       acc_reg, pop_reg;
  logic [15:0]       gen_reg;
  logic [FW-1:0]     frame_cnt_reg;
  logic              done_reg;

  logic              auto_start, clear_acc, load_acc, start_acc, last_cell;
  logic [COLS_LOG2-1:0] cur_col;
  logic [ROWS_LOG2-1:0] cur_row;
  logic [8:0]        window, valid;
  logic [3:0]        nbr_count;
  logic              next_cell;

  assign auto_start = run && frame_tick && (frame_cnt_reg == FW'(GEN_FRAMES - 1));
  assign clear_acc  = (state_reg == IDLE) && clear;
  assign load_acc   = (state_reg == IDLE) && !clear && load_en;
  assign start_acc  = (state_reg == IDLE) && !clear && !load_en && (step || auto_start);
  assign last_cell  = (idx_reg == AW'(N_SIZE - 1));

  assign cur_col = idx_reg[COLS_LOG2-1:0];
  assign cur_row = idx_reg[AW-1:COLS_LOG2];

  // Neighbour addresses wrap by truncation; dead-edge mode masks the wraps off
  for (genvar gi = 0; gi < 9; gi++) begin : g_nbr
    localparam int DR = gi / 3 - 1;
    localparam int DC = gi % 3 - 1;
    logic [COLS_LOG2-1:0] n_col;
    logic [ROWS_LOG2-1:0] n_row;
    assign n_col      = cur_col + COLS_LOG2'(DC);
    assign n_row      = cur_row + ROWS_LOG2'(DR);
    assign window[gi] = front_reg[{n_row, n_col}];
    if (TORUS) begin : g_wrap
      assign valid[gi] = 1'b1;
    end else begin : g_edge
      assign valid[gi] = !((DC < 0 && cur_col == '0) || (DC > 0 && cur_col == '1) ||
                           (DR < 0 && cur_row == '0) || (DR > 0 && cur_row == '1));
    end
  end

  life_rule #(
    .BIRTH_MASK  (BIRTH_MASK),
    .SURVIVE_MASK(SURVIVE_MASK)
  ) u_rule (
    .window   (window),
    .valid    (valid),
    .count    (nbr_count),
    .next_cell(next_cell)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_acc) state_next = COMPUTE;
      COMPUTE: if (last_cell) state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == COMPUTE) || (state_reg == SWAP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      front_reg     <= INIT_PATTERN;
      back_reg      <= '0;
      idx_reg       <= '0;
      acc_reg       <= '0;
      pop_reg       <= INIT_POP;
      gen_reg       <= '0;
      frame_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == SWAP);
      if (run && frame_tick) begin
        frame_cnt_reg <= (frame_cnt_reg == FW'(GEN_FRAMES - 1)) ? '0 : frame_cnt_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (clear_acc) begin
            front_reg     <= INIT_PATTERN;
            gen_reg       <= '0;
            pop_reg       <= INIT_POP;
            frame_cnt_reg <= '0;
          end else if (load_acc) begin
            front_reg[load_addr] <= load_data;
            if (load_data != front_reg[load_addr]) begin
              pop_reg <= load_data ? pop_reg + (AW+1)'(1) : pop_reg - (AW+1)'(1);
            end
          end else if (start_acc) begin
            idx_reg <= '0;
            acc_reg <= '0;
          end
        end
        COMPUTE: begin
          back_reg[idx_reg] <= next_cell;
          acc_reg           <= acc_reg + (AW+1)'(next_cell);
          idx_reg           <= idx_reg + 1'b1;
        end
        SWAP: begin
          front_reg <= back_reg;
          pop_reg   <= acc_reg;
          gen_reg   <= gen_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign rd_cell    = front_reg[{rd_row, rd_col}];
  assign done       = done_reg;
  assign gen_count  = gen_reg;
  assign population = pop_reg;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: three instances (dead-edge, torus, HighLife)
// driven by shared stimulus, each checked against hand-computed boards.
module tb_life_engine;
  import life_pkg::*;

  localparam logic [63:0] INIT2 = 64'h0000_001C_001C_0000;

  logic clk = 1'b0;
  logic rst_n, frame_tick, run, step, clear, load_en, load_data;
  logic [5:0] load_addr;
  logic [2:0] rd_col, rd_row;
  logic [2:0] rd_cell_v, busy_v, done_v;
  logic [15:0] gen_v [3];
  logic [6:0]  pop_v [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  life_engine #(.TORUS(1'b0), .GEN_FRAMES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .clear(clear), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rd_col(rd_col), .rd_row(rd_row), .rd_cell(rd_cell_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .gen_count(gen_v[0]), .population(pop_v[0]));

  life_engine #(.TORUS(1'b1), .GEN_FRAMES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .clear(clear), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rd_col(rd_col), .rd_row(rd_row), .rd_cell(rd_cell_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .gen_count(gen_v[1]), .population(pop_v[1]));

  life_engine #(.TORUS(1'b0), .GEN_FRAMES(3), .BIRTH_MASK(B36_MASK),
                .INIT_PATTERN(INIT2)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .clear(clear), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rd_col(rd_col), .rd_row(rd_row), .rd_cell(rd_cell_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .gen_count(gen_v[2]), .population(pop_v[2]));

  function automatic logic [63:0] cb(input int r, input int c);
    return 64'd1 << (r * 8 + c);
  endfunction

  task automatic read_front(input int d, output logic [63:0] v);
    v = '0;
    for (int i = 0; i < 64; i++) begin
      rd_row = 3'(i >> 3);
      rd_col = 3'(i & 7);
      #1;
      v[i] = rd_cell_v[d];
    end
  endtask

  task automatic clear_board();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic load_cell(input int r, input int c, input logic v);
    @(negedge clk); load_en = 1'b1; load_addr = 6'(r * 8 + c); load_data = v;
    @(negedge clk); load_en = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done_v[0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!done_v[0]) begin
      bad++;
      $display("FAIL %s: done not seen after %0d cycles, required within 200", name, k);
    end
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_step();
      wait_done("step_done");
    end
  endtask

  task automatic test_reset();
    logic [63:0] f;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy_v[0]); end
    total++; if (done_v[0] !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done_v[0]); end
    total++; if (gen_v[0] !== 16'd0) begin bad++; $display("FAIL reset_gen: got %0d expected 0", gen_v[0]); end
    total++; if (pop_v[0] !== 7'd0) begin bad++; $display("FAIL reset_pop0: got %0d expected 0", pop_v[0]); end
    total++; if (pop_v[2] !== 7'd6) begin bad++; $display("FAIL reset_pop_init: got %0d expected 6", pop_v[2]); end
    read_front(2, f);
    total++; if (f !== INIT2) begin bad++; $display("FAIL reset_front_init: got %h expected %h", f, INIT2); end
    read_front(0, f);
    total++; if (f !== 64'd0) begin bad++; $display("FAIL reset_front0: got %h expected 0", f); end
    $display("test_reset: checked");
  endtask

  task automatic test_blinker();
    logic [63:0] f, horiz, vert;
    int k;
    horiz = cb(3, 2) | cb(3, 3) | cb(3, 4);
    vert  = cb(2, 3) | cb(3, 3) | cb(4, 3);
    clear_board();
    load_cell(3, 2, 1'b1); load_cell(3, 3, 1'b1); load_cell(3, 4, 1'b1);
    total++; if (pop_v[0] !== 7'd3) begin bad++; $display("FAIL load_pop: got %0d expected 3", pop_v[0]); end
    pulse_step();
    total++; if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b expected 1", busy_v[0]); end
    k = 1;
    while (!done_v[0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    total++; if (k !== 66) begin bad++; $display("FAIL done_latency: got %0d expected 66", k); end
    @(negedge clk);
    total++; if (done_v[0] !== 1'b0) begin bad++; $display("FAIL done_width: got %b expected 0", done_v[0]); end
    read_front(0, f);
    total++; if (f !== vert) begin bad++; $display("FAIL blinker_gen1: got %h expected %h", f, vert); end
    total++; if (pop_v[0] !== 7'd3) begin bad++; $display("FAIL blinker_pop: got %0d expected 3", pop_v[0]); end
    total++; if (gen_v[0] !== 16'd1) begin bad++; $display("FAIL blinker_gen_count: got %0d expected 1", gen_v[0]); end
    step_n(1);
    read_front(0, f);
    total++; if (f !== horiz) begin bad++; $display("FAIL blinker_gen2: got %h expected %h", f, horiz); end
    total++; if (gen_v[0] !== 16'd2) begin bad++; $display("FAIL blinker_gen_count2: got %0d expected 2", gen_v[0]); end
    $display("test_blinker: checked");
  endtask

  task automatic test_glider();
    logic [63:0] f, shifted, block, wrapped;
    shifted = cb(1, 2) | cb(2, 3) | cb(3, 1) | cb(3, 2) | cb(3, 3);
    block   = cb(6, 6) | cb(6, 7) | cb(7, 6) | cb(7, 7);
    wrapped = cb(6, 7) | cb(7, 0) | cb(0, 6) | cb(0, 7) | cb(0, 0);
    clear_board();
    load_cell(0, 1, 1'b1); load_cell(1, 2, 1'b1);
    load_cell(2, 0, 1'b1); load_cell(2, 1, 1'b1); load_cell(2, 2, 1'b1);
    step_n(4);
    read_front(1, f);
    total++; if (f !== shifted) begin bad++; $display("FAIL glider_torus_shift: got %h expected %h", f, shifted); end
    read_front(0, f);
    total++; if (f !== shifted) begin bad++; $display("FAIL glider_edge_shift: got %h expected %h", f, shifted); end
    total++; if (pop_v[0] !== 7'd5) begin bad++; $display("FAIL glider_pop: got %0d expected 5", pop_v[0]); end
    step_n(20);
    read_front(0, f);
    total++; if (f !== block) begin bad++; $display("FAIL glider_corner_block: got %h expected %h", f, block); end
    total++; if (pop_v[0] !== 7'd4) begin bad++; $display("FAIL glider_block_pop: got %0d expected 4", pop_v[0]); end
    total++; if (gen_v[0] !== 16'd24) begin bad++; $display("FAIL glider_gen_count: got %0d expected 24", gen_v[0]); end
    read_front(1, f);
    total++; if (f !== wrapped) begin bad++; $display("FAIL glider_torus_wrap: got %h expected %h", f, wrapped); end
    total++; if (pop_v[1] !== 7'd5) begin bad++; $display("FAIL glider_torus_pop: got %0d expected 5", pop_v[1]); end
    $display("test_glider: checked");
  endtask

  task automatic test_run();
    int seen;
    clear_board();
    run = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      if (t == 10) run = 1'b0;
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      seen = 0;
      for (int c = 0; c < 80; c++) begin
        if (done_v[0]) seen++;
        @(negedge clk);
      end
      total++;
      if (seen !== ((t <= 9 && t % 3 == 0) ? 1 : 0)) begin
        bad++;
        $display("FAIL run_tick%0d: got %0d done pulses expected %0d", t, seen,
                 (t <= 9 && t % 3 == 0) ? 1 : 0);
      end
    end
    total++; if (gen_v[0] !== 16'd3) begin bad++; $display("FAIL run_gen_count: got %0d expected 3", gen_v[0]); end
    $display("test_run: checked");
  endtask

  task automatic test_back_to_back();
    int seen;
    clear_board();
    pulse_step();
    repeat (10) @(negedge clk);
    pulse_step();
    wait_done("b2b_first_done");
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (done_v[0]) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL b2b_extra_done: got %0d expected 0", seen); end
    total++; if (gen_v[0] !== 16'd1) begin bad++; $display("FAIL b2b_gen_count: got %0d expected 1", gen_v[0]); end
    $display("test_back_to_back: checked");
  endtask

  task automatic test_load_busy();
    clear_board();
    pulse_step();
    load_cell(1, 2, 1'b1);
    wait_done("load_busy_done");
    rd_row = 3'd1; rd_col = 3'd2; #1;
    total++; if (rd_cell_v[0] !== 1'b0) begin bad++; $display("FAIL load_busy_cell: got %b expected 0", rd_cell_v[0]); end
    total++; if (pop_v[0] !== 7'd0) begin bad++; $display("FAIL load_busy_pop: got %0d expected 0", pop_v[0]); end
    @(negedge clk); load_en = 1'b1; load_addr = 6'd10; load_data = 1'b1;
    @(negedge clk); load_en = 1'b0;
    rd_row = 3'd1; rd_col = 3'd2; #1;
    total++; if (rd_cell_v[0] !== 1'b1) begin bad++; $display("FAIL load_idle_cell: got %b expected 1", rd_cell_v[0]); end
    total++; if (pop_v[0] !== 7'd1) begin bad++; $display("FAIL load_idle_pop: got %0d expected 1", pop_v[0]); end
    $display("test_load_busy: checked");
  endtask

  task automatic test_reset_abort();
    logic [63:0] f;
    int seen;
    clear_board();
    load_cell(3, 2, 1'b1); load_cell(3, 3, 1'b1); load_cell(3, 4, 1'b1);
    step_n(1);
    pulse_step();
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", busy_v[0]); end
    total++; if (gen_v[0] !== 16'd0) begin bad++; $display("FAIL abort_gen: got %0d expected 0", gen_v[0]); end
    total++; if (pop_v[2] !== 7'd6) begin bad++; $display("FAIL abort_pop_init: got %0d expected 6", pop_v[2]); end
    read_front(2, f);
    total++; if (f !== INIT2) begin bad++; $display("FAIL abort_front_init: got %h expected %h", f, INIT2); end
    read_front(0, f);
    total++; if (f !== 64'd0) begin bad++; $display("FAIL abort_front0: got %h expected 0", f); end
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_done: got %0d expected 0", seen); end
    $display("test_reset_abort: checked");
  endtask

  task automatic test_highlife();
    clear_board();
    load_cell(2, 2, 1'b1); load_cell(2, 3, 1'b1); load_cell(2, 4, 1'b1);
    load_cell(4, 2, 1'b1); load_cell(4, 3, 1'b1); load_cell(4, 4, 1'b1);
    step_n(1);
    rd_row = 3'd3; rd_col = 3'd3; #1;
    total++; if (rd_cell_v[2] !== 1'b1) begin bad++; $display("FAIL highlife_birth6: got %b expected 1", rd_cell_v[2]); end
    total++; if (rd_cell_v[0] !== 1'b0) begin bad++; $display("FAIL conway_no_birth6: got %b expected 0", rd_cell_v[0]); end
    $display("test_highlife: checked");
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = 1'b0; rd_col = '0; rd_row = '0;
    test_reset();
    test_blinker();
    test_glider();
    test_run();
    test_back_to_back();
    test_load_busy();
    test_reset_abort();
    test_highlife();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded 900000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
